// File: rtl/bcd_pkg.sv
// Shared constants, FSM state encoding and digit helpers for the digit-serial BCD adder.
package bcd_pkg;

    localparam int         DIGIT_W  = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Nines complement of one digit, wrapping mod 16 for non-BCD codes.
    function automatic logic [DIGIT_W-1:0] nines(input logic [DIGIT_W-1:0] d);
        logic [DIGIT_W-1:0] r;
        r = BCD_MAX - d;
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with +6 decimal correction.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a_dig,
    input  logic [DIGIT_W-1:0] b_dig,
    input  logic               cin,
    output logic [DIGIT_W-1:0] dig,
    output logic               cout
);

    logic [DIGIT_W:0] t;

    assign t = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT_W{1'b0}}, cin};

    // Non-BCD inputs follow the same rule; the result is defined but not decimal.
    always_comb begin
        dig  = t[DIGIT_W-1:0];
        cout = 1'b0;
        if (t > {1'b0, BCD_MAX}) begin
            dig  = t[DIGIT_W-1:0] + BCD_CORR;
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_seq_adder.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSB first.
// Optional input digit validity check enabled by defining BCD_CHECK_EN.
module bcd_seq_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      sub,
    input  logic [DIGIT_W*DIGITS-1:0] a,
    input  logic [DIGIT_W*DIGITS-1:0] b,
    input  logic                      carry_in,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] sum,
    output logic                      carry_out,
    output logic                      invalid
);

    localparam int                W        = DIGIT_W * DIGITS;
    localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       a_sr;
    logic [W-1:0]       b_sr;
    logic               sub_r;
    logic               carry_r;

    logic               accept;
    logic               last_dig;
    logic [DIGIT_W-1:0] b_op;
    logic [DIGIT_W-1:0] dig;
    logic               dig_c;
    logic [W-1:0]       sum_next;

    // start is honoured only outside RUN; a request during RUN is dropped.
    assign accept   = start && (state != RUN);
    assign last_dig = (state == RUN) && (idx == LAST_IDX);

    assign b_op = sub_r ? nines(b_sr[DIGIT_W-1:0]) : b_sr[DIGIT_W-1:0];

    bcd_digit_add u_digit_add (
        .a_dig (a_sr[DIGIT_W-1:0]),
        .b_dig (b_op),
        .cin   (carry_r),
        .dig   (dig),
        .cout  (dig_c)
    );

    // New digit enters at the top so digit 0 ends up in the low nibble.
    assign sum_next = (sum >> DIGIT_W) | (W'(dig) << (W - DIGIT_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= start ? RUN : IDLE;
                RUN:     state <= last_dig ? DONE : RUN;
                DONE:    state <= start ? RUN : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            carry_r   <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            idx       <= '0;
            carry_r   <= sub ? ~carry_in : carry_in;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (state == RUN) begin
            idx     <= idx + IDX_ONE;
            carry_r <= dig_c;
            sum     <= sum_next;
            if (last_dig) begin
                carry_out <= dig_c;
            end
        end
    end

    // Operand shift registers carry no reset; they are always loaded on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            sub_r <= sub;
        end else if (state == RUN) begin
            a_sr <= a_sr >> DIGIT_W;
            b_sr <= b_sr >> DIGIT_W;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

`ifdef BCD_CHECK_EN
    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i*DIGIT_W +: DIGIT_W] > BCD_MAX) begin
                r = 1'b1;
            end
        end
        return r;
    endfunction

    logic invalid_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            invalid_r <= 1'b0;
        end else if (accept) begin
            invalid_r <= has_bad_digit(a) | has_bad_digit(b);
        end
    end

    assign invalid = invalid_r;
`else
    assign invalid = 1'b0;
`endif

endmodule
